core_data_obi2axi_bridge: RTL and testbench

- Converts the core's OBI-style data port (req/gnt/rvalid) into single-beat AXI4 master transactions.
- Sits directly upstream of the system-bus crossbar slave port reserved for the core master.
- Allows one outstanding transaction at a time. Returns read data, write completion and bus errors to the core.
- Replaces the ad-hoc conversion logic currently inside the data controller.

---
 rtl/core_bus_pkg.sv | 29 ++
 rtl/core_data_obi2axi_intf.sv | 55 +++++
 rtl/core_data_obi2axi_bridge.sv | 188 ++++++++++++++++++
 tb/tb_core_data_obi2axi_bridge.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_bus_pkg.sv
// Shared definitions for the core data-port bus bridge: AXI response codes,
// single-beat transfer constants and the bridge FSM state encoding.
package core_bus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Every transfer is one 32-bit beat of an INCR burst
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA,
        ST_RESP
    } bridge_state_e;

    // SLVERR and DECERR are errors; OKAY and EXOKAY are not
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/core_data_obi2axi_intf.sv
// AXI-side channel driver for the bridge: turns the FSM state and the
// registered request into the AW/W/B/AR/R channel signals, tying the
// constant ID and protection fields.
module core_data_obi2axi_intf
    import core_bus_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         ID_WIDTH   = 4,
    parameter int         TXN_ID     = 0,
    parameter logic [2:0] AXI_PROT   = 3'b000
) (
    input  bridge_state_e         state_i,
    input  logic                  aw_done_i,
    input  logic                  w_done_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            be_i,

    output logic [ADDR_WIDTH-1:0] aw_addr_o,
    output logic                  aw_valid_o,
    output logic [ID_WIDTH-1:0]   aw_id_o,
    output logic [2:0]            aw_prot_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [3:0]            w_strb_o,
    output logic                  w_valid_o,
    output logic                  b_ready_o,
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    output logic                  ar_valid_o,
    output logic [ID_WIDTH-1:0]   ar_id_o,
    output logic [2:0]            ar_prot_o,
    output logic                  r_ready_o
);

    // Payloads come straight from the request registers, so they are stable
    // for as long as the matching valid is held
    assign aw_addr_o = addr_i;
    assign ar_addr_o = addr_i;
    assign w_data_o  = wdata_i;
    assign w_strb_o  = be_i;
    assign aw_id_o   = ID_WIDTH'(TXN_ID);
    assign ar_id_o   = ID_WIDTH'(TXN_ID);
    assign aw_prot_o = AXI_PROT;
    assign ar_prot_o = AXI_PROT;

    // Channel valids/readies are pure decodes of state; AW and W each drop once their own handshake is recorded
    always_comb begin
        aw_valid_o = (state_i == ST_WRITE) && !aw_done_i;
        w_valid_o  = (state_i == ST_WRITE) && !w_done_i;
        b_ready_o  = (state_i == ST_WRESP);
        ar_valid_o = (state_i == ST_RADDR);
        r_ready_o  = (state_i == ST_RDATA);
    end

endmodule

// File: rtl/core_data_obi2axi_bridge.sv
// OBI (req/gnt/rvalid) to single-beat AXI4 master bridge for the core data
// port. One transaction in flight at a time; read data, write completion and
// bus errors are returned to the core as a one-cycle rvalid pulse.
module core_data_obi2axi_bridge
    import core_bus_pkg::*;
#(
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter int         ID_WIDTH   = 4,
    parameter int         TXN_ID     = 0,
    parameter logic [2:0] AXI_PROT   = 3'b000
) (
    input  logic                  clk_i,
    input  logic                  reset_i,

    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,

    output logic [ADDR_WIDTH-1:0] aw_addr_o,
    output logic                  aw_valid_o,
    output logic [ID_WIDTH-1:0]   aw_id_o,
    output logic [2:0]            aw_prot_o,
    input  logic                  aw_ready_i,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [3:0]            w_strb_o,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    input  logic [1:0]            b_resp_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [ADDR_WIDTH-1:0] ar_addr_o,
    output logic                  ar_valid_o,
    output logic [ID_WIDTH-1:0]   ar_id_o,
    output logic [2:0]            ar_prot_o,
    input  logic                  ar_ready_i,
    input  logic [DATA_WIDTH-1:0] r_data_i,
    input  logic [1:0]            r_resp_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("core_data_obi2axi_bridge: DATA_WIDTH must be 32");
    end

    bridge_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  err_q, err_d;

    core_data_obi2axi_intf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ID_WIDTH   (ID_WIDTH),
        .TXN_ID     (TXN_ID),
        .AXI_PROT   (AXI_PROT)
    ) u_intf (
        .state_i    (state_q),
        .aw_done_i  (aw_done_q),
        .w_done_i   (w_done_q),
        .addr_i     (addr_q),
        .wdata_i    (wdata_q),
        .be_i       (be_q),
        .aw_addr_o  (aw_addr_o),
        .aw_valid_o (aw_valid_o),
        .aw_id_o    (aw_id_o),
        .aw_prot_o  (aw_prot_o),
        .w_data_o   (w_data_o),
        .w_strb_o   (w_strb_o),
        .w_valid_o  (w_valid_o),
        .b_ready_o  (b_ready_o),
        .ar_addr_o  (ar_addr_o),
        .ar_valid_o (ar_valid_o),
        .ar_id_o    (ar_id_o),
        .ar_prot_o  (ar_prot_o),
        .r_ready_o  (r_ready_o)
    );

    // State and request/response registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: capture the request in IDLE, then walk the AXI channels for that access
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (data_req_i) begin
                    // Word-align the address; byte lanes are selected by strobes
                    addr_d    = data_addr_i & ~ADDR_WIDTH'(3);
                    be_d      = data_be_i;
                    wdata_d   = data_wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    err_d     = 1'b0;
                    state_d   = data_we_i ? ST_WRITE : ST_RADDR;
                end
            end
            ST_WRITE: begin
                aw_done_d = aw_done_q || (aw_valid_o && aw_ready_i);
                w_done_d  = w_done_q  || (w_valid_o  && w_ready_i);
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_valid_i) begin
                    err_d   = resp_is_err(b_resp_i);
                    state_d = ST_RESP;
                end
            end
            ST_RADDR: begin
                if (ar_ready_i) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_valid_i) begin
                    // Error responses return zero data rather than whatever the slave drove
                    err_d   = resp_is_err(r_resp_i);
                    rdata_d = resp_is_err(r_resp_i) ? '0 : r_data_i;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Core-side outputs: grant only in IDLE, one-cycle response pulse in RESP
    always_comb begin
        data_gnt_o    = (state_q == ST_IDLE) && data_req_i;
        data_rvalid_o = (state_q == ST_RESP);
        data_err_o    = (state_q == ST_RESP) && err_q;
    end

    assign data_rdata_o = rdata_q;

    a_no_stray_b : assert property (@(posedge clk_i) disable iff (reset_i)
        b_valid_i |-> (state_q == ST_WRESP))
        else $error("b_valid_i seen outside WRESP");

    a_no_stray_r : assert property (@(posedge clk_i) disable iff (reset_i)
        r_valid_i |-> (state_q == ST_RDATA))
        else $error("r_valid_i seen outside RDATA");

endmodule

// File: tb/tb_core_data_obi2axi_bridge.sv
// Directed bench for core_data_obi2axi_bridge. Inputs change at the falling
// edge; outputs are sampled 1ns later, mid-cycle, away from the rising edge.
module tb_core_data_obi2axi_bridge;

    logic        clk_i;
    logic        reset_i;
    logic        data_req_i, data_gnt_o, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic        data_rvalid_o, data_err_o;
    logic [31:0] aw_addr_o, w_data_o, ar_addr_o, r_data_i;
    logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
    logic [3:0]  aw_id_o, ar_id_o, w_strb_o;
    logic [2:0]  aw_prot_o, ar_prot_o;
    logic [1:0]  b_resp_i, r_resp_i;
    logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i;
    logic        r_valid_i, r_ready_o;
    logic        b_go, r_go;

    int checks = 0;
    int errors = 0;

    // Slave responds only while the bridge is ready, so no stray responses reach it
    assign b_valid_i = b_go & b_ready_o;
    assign r_valid_i = r_go & r_ready_o;

    core_data_obi2axi_bridge dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .aw_addr_o(aw_addr_o), .aw_valid_o(aw_valid_o), .aw_id_o(aw_id_o), .aw_prot_o(aw_prot_o),
        .aw_ready_i(aw_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o),
        .w_ready_i(w_ready_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_addr_o(ar_addr_o), .ar_valid_o(ar_valid_o), .ar_id_o(ar_id_o), .ar_prot_o(ar_prot_o),
        .ar_ready_i(ar_ready_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i),
        .r_ready_o(r_ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_i = 1'b1; data_req_i = 0; data_we_i = 0; data_be_i = 0;
        data_addr_i = 0; data_wdata_i = 0;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
        b_go = 0; r_go = 0; b_resp_i = 0; r_resp_i = 0; r_data_i = 0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++; if ({data_gnt_o, data_rvalid_o, data_err_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o} !== 8'h00) begin
            errors++; $display("FAIL rst_ctrl: got %b expected 00000000", {data_gnt_o, data_rvalid_o, data_err_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o}); end
        checks++; if ({aw_addr_o, w_data_o, w_strb_o, ar_addr_o, data_rdata_o} !== '0) begin
            errors++; $display("FAIL rst_data: got aw=%h w=%h s=%h ar=%h rd=%h expected all 0", aw_addr_o, w_data_o, w_strb_o, ar_addr_o, data_rdata_o); end
        @(negedge clk_i); reset_i = 1'b0;
    endtask

    task automatic test_single_write();
        @(negedge clk_i);
        data_req_i = 1; data_we_i = 1; data_addr_i = 32'h2000_0006; data_be_i = 4'b1100;
        data_wdata_i = 32'hDEAD_BEEF; aw_ready_i = 1; w_ready_i = 1; b_go = 1; b_resp_i = 2'b00;
        #1;
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt_c0: got %b expected 1", data_gnt_o); end
        @(negedge clk_i); data_req_i = 0; #1;
        checks++; if ({aw_valid_o, w_valid_o, ar_valid_o} !== 3'b110) begin errors++; $display("FAIL wr_valids_c1: got %b expected 110", {aw_valid_o, w_valid_o, ar_valid_o}); end
        checks++; if (aw_addr_o !== 32'h2000_0004) begin errors++; $display("FAIL wr_awaddr: got %h expected 20000004", aw_addr_o); end
        checks++; if ({w_strb_o, w_data_o} !== {4'b1100, 32'hDEAD_BEEF}) begin errors++; $display("FAIL wr_wdata: got %b %h expected 1100 deadbeef", w_strb_o, w_data_o); end
        checks++; if ({aw_id_o, aw_prot_o} !== 7'd0) begin errors++; $display("FAIL wr_id_prot: got %h %h expected 0 0", aw_id_o, aw_prot_o); end
        @(negedge clk_i); #1;
        checks++; if ({b_ready_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL wr_bready_c2: got %b expected 10", {b_ready_o, data_rvalid_o}); end
        @(negedge clk_i); #1;
        checks++; if ({data_rvalid_o, data_err_o} !== 2'b10) begin errors++; $display("FAIL wr_rvalid_c3: got %b expected 10", {data_rvalid_o, data_err_o}); end
        @(negedge clk_i); #1;
        checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_rvalid_pulse: got %b expected 0", data_rvalid_o); end
    endtask

    task automatic test_read_delayed();
        @(negedge clk_i);
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h1000_0013; ar_ready_i = 0; r_go = 0;
        #1;
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b expected 1", data_gnt_o); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i); data_req_i = 0; ar_ready_i = (i == 4); #1;
            checks++; if ({ar_valid_o, ar_addr_o} !== {1'b1, 32'h1000_0010}) begin
                errors++; $display("FAIL rd_ar_hold_%0d: got %b %h expected 1 10000010", i, ar_valid_o, ar_addr_o); end
        end
        @(negedge clk_i); ar_ready_i = 0; #1;
        checks++; if ({ar_valid_o, r_ready_o, data_rvalid_o} !== 3'b010) begin errors++; $display("FAIL rd_after_ar: got %b expected 010", {ar_valid_o, r_ready_o, data_rvalid_o}); end
        @(negedge clk_i); r_go = 1; r_data_i = 32'h1234_5678; r_resp_i = 2'b00; #1;
        checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_early_rvalid: got %b expected 0", data_rvalid_o); end
        @(negedge clk_i); r_go = 0; #1;
        checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'h1234_5678}) begin
            errors++; $display("FAIL rd_resp: got %b %b %h expected 1 0 12345678", data_rvalid_o, data_err_o, data_rdata_o); end
        @(negedge clk_i); #1;
        checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL rd_rvalid_pulse: got %b expected 0", data_rvalid_o); end
    endtask

    task automatic test_write_split();
        logic [3:0] exp_v, obs_v;
        int rv_cnt;
        rv_cnt = 0;
        @(negedge clk_i);
        data_req_i = 1; data_we_i = 1; data_addr_i = 32'h2000_0100; data_be_i = 4'b0000;
        data_wdata_i = 32'h0102_0304; aw_ready_i = 1; w_ready_i = 0; b_go = 1; b_resp_i = 2'b00;
        #1;
        checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL split_gnt: got %b expected 1", data_gnt_o); end
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk_i); data_req_i = 0; w_ready_i = (i == 4); #1;
            exp_v = {i == 1, (i >= 1) && (i <= 4), i == 5, i == 6};
            obs_v = {aw_valid_o, w_valid_o, b_ready_o, data_rvalid_o};
            if (data_rvalid_o === 1'b1) rv_cnt++;
            checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL split_c%0d {awv,wv,brdy,rvalid}: got %b expected %b", i, obs_v, exp_v); end
            if (i == 4) begin
                checks++; if (w_strb_o !== 4'b0000) begin errors++; $display("FAIL split_strb0: got %b expected 0000", w_strb_o); end
            end
        end
        checks++; if (rv_cnt != 1) begin errors++; $display("FAIL split_rvalid_count: got %0d expected 1", rv_cnt); end
    endtask

    task automatic test_errors();
        // Read to unmapped space, DECERR
        @(negedge clk_i);
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'hF000_0000; aw_ready_i = 1; w_ready_i = 1;
        ar_ready_i = 1; r_go = 1; r_resp_i = 2'b11; r_data_i = 32'hFFFF_FFFF;
        @(negedge clk_i); data_req_i = 0;
        @(negedge clk_i);
        @(negedge clk_i); #1;
        checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b11, 32'h0}) begin
            errors++; $display("FAIL decerr: got %b %b %h expected 1 1 00000000", data_rvalid_o, data_err_o, data_rdata_o); end
        // Write answered with SLVERR
        @(negedge clk_i);
        data_req_i = 1; data_we_i = 1; data_addr_i = 32'h2000_0200; data_be_i = 4'hF; b_go = 1; b_resp_i = 2'b10;
        @(negedge clk_i); data_req_i = 0;
        @(negedge clk_i);
        @(negedge clk_i); #1;
        checks++; if ({data_rvalid_o, data_err_o} !== 2'b11) begin errors++; $display("FAIL slverr: got %b expected 11", {data_rvalid_o, data_err_o}); end
        // EXOKAY read carries data and no error
        @(negedge clk_i);
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h1000_0040; r_resp_i = 2'b01; r_data_i = 32'hA5A5_0001;
        @(negedge clk_i); data_req_i = 0;
        @(negedge clk_i);
        @(negedge clk_i); #1;
        checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'hA5A5_0001}) begin
            errors++; $display("FAIL exokay: got %b %b %h expected 1 0 a5a50001", data_rvalid_o, data_err_o, data_rdata_o); end
        b_resp_i = 2'b00; r_resp_i = 2'b00;
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp_v, obs_v;
        logic kind_w;
        int ph;
        aw_ready_i = 1; w_ready_i = 1; ar_ready_i = 1; b_go = 1; r_go = 1;
        b_resp_i = 2'b00; r_resp_i = 2'b00; r_data_i = 32'hCAFE_0005;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            kind_w = ((i / 4) != 1);
            data_req_i = 1; data_we_i = kind_w; data_addr_i = 32'h3000_0000 + 32'(i * 4);
            data_be_i = 4'hF; data_wdata_i = 32'h7700_0000 + 32'(i);
            #1;
            ph = i % 4;
            exp_v = {ph == 0, (ph == 1) && kind_w, (ph == 1) && kind_w, (ph == 2) && kind_w,
                     (ph == 1) && !kind_w, (ph == 2) && !kind_w, ph == 3};
            obs_v = {data_gnt_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, data_rvalid_o};
            checks++; if (obs_v !== exp_v) begin errors++; $display("FAIL b2b_c%0d {gnt,awv,wv,brdy,arv,rrdy,rvalid}: got %b expected %b", i, obs_v, exp_v); end
            if (i == 5) begin
                checks++; if (ar_addr_o !== 32'h3000_0010) begin errors++; $display("FAIL b2b_araddr: got %h expected 30000010", ar_addr_o); end
            end
            if (i == 7) begin
                checks++; if (data_rdata_o !== 32'hCAFE_0005) begin errors++; $display("FAIL b2b_rdata: got %h expected cafe0005", data_rdata_o); end
            end
            if (i == 9) begin
                checks++; if ({aw_addr_o, w_data_o} !== {32'h3000_0020, 32'h7700_0008}) begin
                    errors++; $display("FAIL b2b_w2: got %h %h expected 30000020 77000008", aw_addr_o, w_data_o); end
            end
        end
        @(negedge clk_i); data_req_i = 0; #1;
        checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gnt: got %b expected 0", data_gnt_o); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        data_req_i = 1; data_we_i = 1; data_addr_i = 32'h4000_0008; data_be_i = 4'hF;
        data_wdata_i = 32'h55AA_55AA; aw_ready_i = 1; w_ready_i = 1; b_go = 0; r_go = 0;
        @(negedge clk_i); data_req_i = 0;
        @(negedge clk_i); #1;
        checks++; if (b_ready_o !== 1'b1) begin errors++; $display("FAIL rstmid_in_wresp: got %b expected 1", b_ready_o); end
        reset_i = 1'b1;
        @(negedge clk_i); reset_i = 1'b0; #1;
        checks++; if ({data_gnt_o, data_rvalid_o, data_err_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o} !== 8'h00) begin
            errors++; $display("FAIL rstmid_ctrl: got %b expected 00000000", {data_gnt_o, data_rvalid_o, data_err_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o}); end
        checks++; if ({aw_addr_o, w_data_o, w_strb_o, data_rdata_o} !== '0) begin
            errors++; $display("FAIL rstmid_data: got %h %h %h %h expected all 0", aw_addr_o, w_data_o, w_strb_o, data_rdata_o); end
        @(negedge clk_i);
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h4000_0010; r_go = 1; r_resp_i = 2'b00; r_data_i = 32'h0BAD_F00D;
        #1;
        checks++; if ({data_gnt_o, data_rvalid_o} !== 2'b10) begin errors++; $display("FAIL rstmid_regrant: got %b expected 10", {data_gnt_o, data_rvalid_o}); end
        @(negedge clk_i); data_req_i = 0; #1;
        checks++; if ({ar_valid_o, ar_addr_o, data_rvalid_o} !== {1'b1, 32'h4000_0010, 1'b0}) begin
            errors++; $display("FAIL rstmid_ar: got %b %h %b expected 1 40000010 0", ar_valid_o, ar_addr_o, data_rvalid_o); end
        @(negedge clk_i);
        @(negedge clk_i); #1;
        checks++; if ({data_rvalid_o, data_err_o, data_rdata_o} !== {2'b10, 32'h0BAD_F00D}) begin
            errors++; $display("FAIL rstmid_read: got %b %b %h expected 1 0 0badf00d", data_rvalid_o, data_err_o, data_rdata_o); end
        r_go = 0;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_delayed();
        test_write_split();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
